// File: rtl/counter_delayed_trigger.sv
// Delayed trigger: measures the counter_reset period and, once armed, raises a
// sticky trigger a programmable number of cycles before the next boundary.
module counter_delayed_trigger #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 arm,
  input  logic                 trigger_reset,
  input  logic                 counter_reset,
  input  logic [CNT_WIDTH-1:0] presamples,
  output logic                 trigger,
  output logic                 armed_status
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // State bit 1 is the trigger flop, bit 0 the armed flop; never both set.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_FIRED = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic                   arm_q, cr_q;
  logic                   period_valid_q;
  logic [CNT_WIDTH-1:0]   counter_q, period_len_q, presamples_q;
  logic [CNT_WIDTH-1:0]   target_c;
  logic                   arm_ev_c, cr_ev_c, fire_c, latch_c;

  assign arm_ev_c = arm & ~arm_q;
  assign cr_ev_c  = counter_reset & ~cr_q;

  // Fire point inside the period; out-of-range presamples fire at period start.
  always_comb begin
    target_c = '0;
    if ((presamples_q != '0) && (presamples_q < period_len_q)) begin
      target_c = period_len_q - presamples_q;
    end
  end

  assign fire_c = period_valid_q && (counter_q == target_c);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // trigger_reset outranks fire, which outranks a re-arm in the same cycle.
  always_comb begin
    state_d = state_q;
    latch_c = 1'b0;
    if (trigger_reset) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_ev_c) begin
            state_d = ST_ARMED;
            latch_c = 1'b1;
          end
        end
        ST_ARMED: begin
          if (fire_c) begin
            state_d = ST_FIRED;
          end else if (arm_ev_c) begin
            latch_c = 1'b1;
          end
        end
        ST_FIRED: state_d = ST_FIRED;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign trigger      = state_q[1];
  assign armed_status = state_q[0];

  // Edge detectors, saturating period counter and presamples latch.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      arm_q          <= 1'b0;
      cr_q           <= 1'b0;
      counter_q      <= '0;
      period_len_q   <= '0;
      period_valid_q <= 1'b0;
      presamples_q   <= '0;
    end else begin
      arm_q <= arm;
      cr_q  <= counter_reset;
      if (cr_ev_c) begin
        period_len_q   <= (counter_q == CNT_MAX) ? CNT_MAX : counter_q + CNT_ONE;
        counter_q      <= '0;
        period_valid_q <= 1'b1;
      end else if (counter_q != CNT_MAX) begin
        counter_q <= counter_q + CNT_ONE;
      end
      if (latch_c) begin
        presamples_q <= presamples;
      end
    end
  end

endmodule

// File: tb/tb_counter_delayed_trigger.sv
// Directed bench for counter_delayed_trigger: scenario table plus hand-written
// sequences for reset, stickiness, clear/re-arm and clear-vs-fire priority.
module tb_counter_delayed_trigger;

  localparam int unsigned W = 32;

  logic         clk;
  logic         areset;
  logic         arm;
  logic         trigger_reset;
  logic         counter_reset;
  logic [W-1:0] presamples;
  logic         trigger;
  logic         armed_status;

  int checks;
  int errors;

  counter_delayed_trigger #(.CNT_WIDTH(W)) dut (
    .clk           (clk),
    .areset        (areset),
    .arm           (arm),
    .trigger_reset (trigger_reset),
    .counter_reset (counter_reset),
    .presamples    (presamples),
    .trigger       (trigger),
    .armed_status  (armed_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample c is taken 1 time unit after the posedge that consumed cycle c inputs.
  typedef struct {
    int pre;
    int hold;
    int e0;
    int e1;
    int e2;
    int e3;
    int arm_cyc;
    int exp_rise;
  } vec_t;

  vec_t vecs[9];

  task automatic check_bit(input string name, input int cyc, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0b want %0b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic cr, input logic a, input logic tr);
    counter_reset = cr;
    arm           = a;
    trigger_reset = tr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset        = 1'b1;
    arm           = 1'b0;
    trigger_reset = 1'b0;
    counter_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    areset = 1'b0;
  endtask

  function automatic logic in_pulse(input int c, input int e, input int hold);
    return (e >= 0) && (c >= e) && (c < e + hold);
  endfunction

  initial begin
    int first;
    logic cr;
    checks        = 0;
    errors        = 0;
    areset        = 1'b1;
    arm           = 1'b0;
    trigger_reset = 1'b0;
    counter_reset = 1'b0;
    presamples    = '0;

    //          pre  hold  e0    e1    e2    e3   arm   rise
    vecs[0] = '{50,  12,   10,   410,  810,  1210, 510,  761};   // basic
    vecs[1] = '{0,   12,   10,   410,  810,  1210, 510,  811};   // presamples 0
    vecs[2] = '{400, 12,   10,   410,  810,  1210, 510,  811};   // presamples >= period
    vecs[3] = '{1,   12,   10,   410,  810,  1210, 510,  810};   // fire coincides with boundary
    vecs[4] = '{399, 12,   10,   410,  810,  1210, 510,  812};   // target passed -> next period
    vecs[5] = '{50,  100,  10,   410,  810,  1210, 560,  761};   // long counter_reset level
    vecs[6] = '{50,  12,   10,   410,  810,  1110, 780,  1361};  // period shrinks to 300
    vecs[7] = '{50,  12,   1000, 1400, -1,   -1,   2,    1751};  // armed before any boundary
    vecs[8] = '{7,   3,    10,   30,   50,   70,   35,   44};    // short 20-cycle period

    // Reset holds outputs low despite input activity.
    areset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      presamples = W'(c);
      step(c[1], c[0], 1'b0);
      check_bit("reset_trigger", c, trigger, 1'b0);
      check_bit("reset_armed", c, armed_status, 1'b0);
    end

    for (int i = 0; i < 9; i++) begin
      do_reset();
      presamples = W'(vecs[i].pre);
      first = -1;
      for (int c = 0; c <= vecs[i].exp_rise + 3; c++) begin
        cr = in_pulse(c, vecs[i].e0, vecs[i].hold) | in_pulse(c, vecs[i].e1, vecs[i].hold) |
             in_pulse(c, vecs[i].e2, vecs[i].hold) | in_pulse(c, vecs[i].e3, vecs[i].hold);
        step(cr, c == vecs[i].arm_cyc, 1'b0);
        if (c == vecs[i].arm_cyc) check_bit($sformatf("vec%0d_armed", i), c, armed_status, 1'b1);
        if (trigger && first < 0) first = c;
        if (c == vecs[i].exp_rise) check_bit($sformatf("vec%0d_armed_drop", i), c, armed_status, 1'b0);
      end
      check_int($sformatf("vec%0d_rise_cycle", i), first, vecs[i].exp_rise);
    end

    // Stickiness, clear with simultaneous arm, re-arm, clear beating fire.
    do_reset();
    presamples = W'(50);
    for (int c = 0; c <= 1990; c++) begin
      cr = (c >= 10) && (((c - 10) % 400) < 12);
      step(cr, (c == 510) || (c == 900) || (c == 1000) || (c == 1300) || (c == 1320) || (c == 1650),
           (c == 1300) || (c == 1600) || (c == 1961));
      case (c)
        510:  check_bit("seq_armed", c, armed_status, 1'b1);
        760:  check_bit("seq_pre_fire", c, trigger, 1'b0);
        761:  begin
                check_bit("seq_fire", c, trigger, 1'b1);
                check_bit("seq_armed_drop", c, armed_status, 1'b0);
              end
        811, 1001, 1211: check_bit("seq_sticky", c, trigger, 1'b1);
        901:  begin
                check_bit("seq_sticky_arm", c, trigger, 1'b1);
                check_bit("seq_arm_ignored", c, armed_status, 1'b0);
              end
        1300: begin
                check_bit("seq_clear", c, trigger, 1'b0);
                check_bit("seq_clear_arm_ignored", c, armed_status, 1'b0);
              end
        1320: check_bit("seq_rearm", c, armed_status, 1'b1);
        1560: check_bit("seq_refire_early", c, trigger, 1'b0);
        1561: check_bit("seq_refire", c, trigger, 1'b1);
        1600: check_bit("seq_clear2", c, trigger, 1'b0);
        1650: check_bit("seq_rearm2", c, armed_status, 1'b1);
        1961: begin
                check_bit("seq_clear_beats_fire", c, trigger, 1'b0);
                check_bit("seq_clear_disarms", c, armed_status, 1'b0);
              end
        1990: check_bit("seq_stays_clear", c, trigger, 1'b0);
        default: ;
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
